// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Counter must hold 0..LENGTH, since it steps past LENGTH-1 on the final iteration.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/fulladder.sv
// LENGTH-bit ripple adder with carry in/out.
module fulladder #(
  parameter int LENGTH = 32
) (
  input  logic [LENGTH-1:0] a,
  input  logic [LENGTH-1:0] b,
  input  logic              cin,
  output logic [LENGTH-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LENGTH{1'b0}}, cin};

endmodule

// File: rtl/mul_shift_add.sv
// Multi-cycle unsigned shift-add multiplier, one multiplier bit per clock,
// valid/ready on both sides.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LENGTH-1:0]     op_a,
  input  logic [LENGTH-1:0]     op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LENGTH-1:0]   product,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(LENGTH);

  mul_state_t state_q, state_d;

  logic [CNT_W-1:0]    cnt_q;
  logic [LENGTH-1:0]   mcand_q, acc_hi_q, acc_lo_q;
  logic [LENGTH-1:0]   addend, sum;
  logic                cout;
  logic                last;
  logic [2*LENGTH-1:0] product_q;

  assign last   = (cnt_q == CNT_W'(LENGTH - 1));
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  fulladder #(.LENGTH(LENGTH)) u_add (
    .a    (acc_hi_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // {acc_hi,acc_lo} <= {cout,sum,acc_lo} >> 1; product is captured on the
  // final iteration so it holds steady through DONE and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= op_a;
            acc_hi_q <= '0;
            acc_lo_q <= op_b;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          acc_hi_q <= {cout, sum[LENGTH-1:1]};
          acc_lo_q <= {sum[0], acc_lo_q[LENGTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last) product_q <= {cout, sum, acc_lo_q[LENGTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Scoreboard bench: directed LENGTH=4 cases and random LENGTH=32 streaming.
module tb_mul_shift_add;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // LENGTH=4 instance
  logic       iv4, ir4, ov4, or4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  // LENGTH=32 instance
  logic        iv32, ir32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;

  mul_shift_add #(.LENGTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4),
    .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4)
  );

  mul_shift_add #(.LENGTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op_a(a32), .op_b(b32),
    .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int hs4    = 0;
  int hs32   = 0;
  logic [7:0]  q4[$];
  logic [63:0] q32[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Handoff happens at the next posedge when valid&ready are seen here.
  always @(negedge clk) begin
    if (rst_n && ov4 && or4) begin
      chk("sb4_nonempty", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) chk("sb4_product", 64'(p4), 64'(q4.pop_front()));
      hs4++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov32 && or32) begin
      chk("sb32_nonempty", 64'(q32.size() != 0), 64'd1);
      if (hs32 == 0) chk("maxmax32", p32, 64'hFFFFFFFE00000001);
      if (q32.size() != 0) chk("sb32_product", p32, q32.pop_front());
      hs32++;
    end
  end

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input int hold);
    int cyc;
    logic [7:0] e;
    e = 8'(a) * 8'(b);
    @(posedge clk); #1;
    chk("in_ready4_idle", 64'(ir4), 64'd1);
    iv4 = 1'b1; a4 = a; b4 = b;
    q4.push_back(e);
    @(posedge clk); #1;  // t0: accepted
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    chk("busy4_run", 64'(busy4), 64'd1);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ov4 && cyc < 50);
    chk("latency4", 64'(cyc), 64'd4);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid4", 64'(ov4), 64'd1);
      chk("hold_prod4", 64'(p4), 64'(e));
      chk("hold_ready4", 64'(ir4), 64'd0);
      if (k == 1) begin iv4 = 1'b1; a4 = 4'd3; b4 = 4'd3; end
      else iv4 = 1'b0;
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    chk("post_valid4", 64'(ov4), 64'd0);
    chk("post_ready4", 64'(ir4), 64'd1);
  endtask

  initial begin
    int acc, guard;
    logic took;
    rst_n = 1'b0;
    iv4 = 0; or4 = 0; a4 = 0; b4 = 0;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_prod4", 64'(p4), 64'd0);
    chk("rst_valid4", 64'(ov4), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_ready4", 64'(ir4), 64'd1);
    chk("rst_prod32", p32, 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);

    run4(4'd8, 4'd7, 0);
    run4(4'd7, 4'd9, 0);
    run4(4'd15, 4'd15, 0);
    run4(4'd0, 4'd0, 0);
    run4(4'd0, 4'd15, 0);
    run4(4'd15, 4'd0, 0);
    chk("handoffs4_a", 64'(hs4), 64'd6);

    run4(4'd8, 4'd7, 5);
    chk("handoffs4_bp", 64'(hs4), 64'd7);
    chk("bp_no_accept", 64'(busy4), 64'd0);
    chk("bp_sb_empty", 64'(q4.size()), 64'd0);

    // Reset two iterations into 15x15
    @(posedge clk); #1;
    iv4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_prod4", 64'(p4), 64'd0);
    chk("midrst_valid4", 64'(ov4), 64'd0);
    chk("midrst_busy4", 64'(busy4), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run4(4'd2, 4'd3, 0);
    chk("handoffs4_end", 64'(hs4), 64'd8);

    // LENGTH=32 streaming: in_valid held, random backpressure
    acc = 0; guard = 0;
    @(posedge clk); #1;
    iv32 = 1'b1; a32 = '1; b32 = '1; or32 = 1'($urandom);
    while (acc < 201 && guard < 40000) begin
      @(negedge clk);
      took = ir32;
      if (took) begin
        q32.push_back(64'(a32) * 64'(b32));
        acc++;
      end
      @(posedge clk); #1;
      guard++;
      or32 = 1'($urandom);
      if (took) begin a32 = $urandom; b32 = $urandom; end
    end
    iv32 = 1'b0;
    guard = 0;
    while (q32.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      or32 = 1'($urandom);
      guard++;
    end
    or32 = 1'b0;
    chk("accepted32", 64'(acc), 64'd201);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("handoffs32", 64'(hs32), 64'd201);
    repeat (40) @(posedge clk);
    chk("no_dup32", 64'(hs32), 64'd201);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
